configure_machine_batch: RTL and testbench

Streaming, parametrised machine configurator for the day-10 light puzzle. It accepts one machine description per valid/ready handshake and searches every button subset, evaluating LANES candidates per cycle. It emits the minimum-press solution per machine, or a flag when no subset reaches the target, and keeps a saturating running total of presses across machines. It sits between the input parser and the top-level answer reporter.

---
 rtl/day10_pkg.sv | 7 +
 rtl/button_subset_eval.sv | 27 ++
 rtl/configure_machine_batch.sv | 114 +++++++++++
 tb/tb_configure_machine_batch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/day10_pkg.sv
// day10_pkg: FSM state type and width helper shared by the machine configurator blocks
package day10_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, EMIT} state_t;
  function automatic int width_of(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/button_subset_eval.sv
// button_subset_eval: checks one candidate button subset (live, match, popcount)
module button_subset_eval #(
  parameter int NL = 10,
  parameter int NB = 13,
  parameter int LW = 4,
  parameter int BW = 4
) (
  input  logic [NB:0]      candidate,
  input  logic [NB*NL-1:0] buttons,
  input  logic [NL-1:0]    target,
  input  logic [LW-1:0]    num_lights,
  input  logic [BW-1:0]    num_buttons,
  output logic             live,
  output logic             match,
  output logic [BW-1:0]    popcount
);
  logic [NL-1:0] acc;
  logic [NL:0] mask;
  always_comb begin
    acc = '0;
    for (int b = 0; b < NB; b++) acc = candidate[b] ? acc ^ buttons[b*NL +: NL] : acc;
  end
  assign mask = ((NL+1)'(1) << num_lights) - (NL+1)'(1);
  assign live = candidate < ((NB+1)'(1) << num_buttons);
  assign match = live && (({1'b0, acc ^ target} & mask) == '0);
  assign popcount = BW'($countones(candidate[NB-1:0]));
endmodule

// File: rtl/configure_machine_batch.sv
// configure_machine_batch: exhaustive min-press search per machine with running totals
module configure_machine_batch
  import day10_pkg::*;
#(
  parameter int MAX_NUM_LIGHTS  = 10,
  parameter int MAX_NUM_BUTTONS = 13,
  parameter int LANES           = 4,
  parameter int TOTAL_W         = 16,
  parameter int CNT_W           = 16,
  parameter int LIGHTS_W        = width_of(MAX_NUM_LIGHTS),
  parameter int BUTTONS_W       = width_of(MAX_NUM_BUTTONS)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [LIGHTS_W-1:0]                      in_num_lights,
  input  logic [BUTTONS_W-1:0]                     in_num_buttons,
  input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] in_buttons,
  input  logic [MAX_NUM_LIGHTS-1:0]                in_target,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_feasible,
  output logic [BUTTONS_W-1:0]                     out_min_presses,
  output logic [MAX_NUM_BUTTONS-1:0]               out_buttons_to_press,
  input  logic                                     clear_total,
  output logic [TOTAL_W-1:0]                       total_presses,
  output logic [CNT_W-1:0]                         machines_done
);
  localparam int NL = MAX_NUM_LIGHTS;
  localparam int NB = MAX_NUM_BUTTONS;
  state_t state, state_nxt;
  logic [LIGHTS_W-1:0] nl_q;
  logic [BUTTONS_W-1:0] nb_q;
  logic [NB*NL-1:0] btn_q;
  logic [NL-1:0] tgt_q;
  logic [NB:0] base;
  logic [NB:0] cand [LANES];
  logic [LANES-1:0] live, match;
  logic [BUTTONS_W-1:0] pc [LANES];
  logic any;
  logic [BUTTONS_W-1:0] lane_cnt;
  logic [NB-1:0] lane_set;
  logic [NB+1:0] nxt_base;
  logic last;
  logic [TOTAL_W:0] sum;
  assign in_ready = state == IDLE;
  assign out_valid = state == EMIT;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign cand[i] = base + (NB+1)'(i);
    button_subset_eval #(.NL(NL), .NB(NB), .LW(LIGHTS_W), .BW(BUTTONS_W)) u_eval (
      .candidate(cand[i]), .buttons(btn_q), .target(tgt_q), .num_lights(nl_q),
      .num_buttons(nb_q), .live(live[i]), .match(match[i]), .popcount(pc[i])
    );
  end
  // lanes are scanned in ascending candidate order, so strict-less keeps the lowest tie
  always_comb begin
    any = 1'b0;
    lane_cnt = '1;
    lane_set = '0;
    for (int i = 0; i < LANES; i++) begin
      if (live[i] && match[i] && (!any || pc[i] < lane_cnt)) begin
        any = 1'b1;
        lane_cnt = pc[i];
        lane_set = cand[i][NB-1:0];
      end
    end
  end
  assign nxt_base = {1'b0, base} + (NB+2)'(LANES);
  assign last = nxt_base >= ((NB+2)'(1) << nb_q) || (any && lane_cnt == '0);
  assign sum = {1'b0, total_presses} + (TOTAL_W+1)'(out_min_presses);
  always_comb begin
    state_nxt = state == IDLE   ? (in_valid ? SEARCH : IDLE) :
                state == SEARCH ? (last ? EMIT : SEARCH) :
                                  (out_ready ? IDLE : EMIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_feasible <= 1'b0;
      out_min_presses <= '1;
      out_buttons_to_press <= '0;
      total_presses <= '0;
      machines_done <= '0;
    end else begin
      state <= state_nxt;
      if (in_valid && in_ready) begin
        nl_q <= in_num_lights > LIGHTS_W'(NL) ? LIGHTS_W'(NL) : in_num_lights;
        nb_q <= in_num_buttons > BUTTONS_W'(NB) ? BUTTONS_W'(NB) : in_num_buttons;
        btn_q <= in_buttons;
        tgt_q <= in_target;
        base <= '0;
        out_feasible <= 1'b0;
        out_min_presses <= '1;
        out_buttons_to_press <= '0;
      end else if (state == SEARCH) begin
        base <= nxt_base[NB:0];
        // the found flag guards the first match even when popcount can equal all-ones
        if (any && (!out_feasible || lane_cnt < out_min_presses)) begin
          out_feasible <= 1'b1;
          out_min_presses <= lane_cnt;
          out_buttons_to_press <= lane_set;
        end
      end
      if (clear_total) begin
        total_presses <= '0;
        machines_done <= '0;
      end else if (out_valid && out_ready) begin
        machines_done <= machines_done + 1'b1;
        if (out_feasible) total_presses <= sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_configure_machine_batch.sv
// tb_configure_machine_batch: randomized check of the configurator against a brute-force model
module tb_configure_machine_batch;
  localparam int NL = 10;
  localparam int NB = 13;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 0, clear_total = 0;
  logic [3:0] in_num_lights = 0, in_num_buttons = 0;
  logic [NB*NL-1:0] in_buttons = '0;
  logic [NL-1:0] in_target = '0;
  logic in_ready, out_valid, out_feasible;
  logic [3:0] out_min_presses;
  logic [NB-1:0] out_buttons_to_press;
  logic [15:0] total_presses, machines_done;
  logic s_in_ready, s_out_valid, s_out_feasible;
  logic [3:0] s_out_min_presses, s_total;
  logic [NB-1:0] s_out_buttons;
  logic [15:0] s_machines_done;
  int checks = 0, errors = 0;
  int tot = 0, tot4 = 0, done = 0;
  always #5 clk = ~clk;
  configure_machine_batch u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_num_lights(in_num_lights), .in_num_buttons(in_num_buttons), .in_buttons(in_buttons),
    .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_feasible(out_feasible), .out_min_presses(out_min_presses),
    .out_buttons_to_press(out_buttons_to_press), .clear_total(clear_total),
    .total_presses(total_presses), .machines_done(machines_done)
  );
  configure_machine_batch #(.TOTAL_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_num_lights(in_num_lights), .in_num_buttons(in_num_buttons), .in_buttons(in_buttons),
    .in_target(in_target), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_feasible(s_out_feasible), .out_min_presses(s_out_min_presses),
    .out_buttons_to_press(s_out_buttons), .clear_total(clear_total),
    .total_presses(s_total), .machines_done(s_machines_done)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void model(input int nl_in, input int nb_in, input logic [NB*NL-1:0] b,
                                input logic [NL-1:0] t, output bit f, output int mn,
                                output int set, output int cyc);
    int nl = nl_in > NL ? NL : nl_in;
    int nb = nb_in > NB ? NB : nb_in;
    int mask = (1 << nl) - 1;
    f = 0; mn = 15; set = 0;
    for (int c = 0; c < (1 << nb); c++) begin
      int acc = 0;
      for (int k = 0; k < nb; k++) if (c[k]) acc = acc ^ int'(b[k*NL +: NL]);
      if (((acc ^ int'(t)) & mask) == 0 && (!f || $countones(c) < mn)) begin
        f = 1; mn = $countones(c); set = c;
      end
    end
    cyc = ((int'(t) & mask) == 0) ? 1 : ((1 << nb) + 3) / 4;
  endfunction
  task automatic run_machine(input int nl, input int nb, input logic [NB*NL-1:0] b,
                             input logic [NL-1:0] t, input int hold, input bit clr);
    bit f; int mn, set, cyc, n;
    model(nl, nb, b, t, f, mn, set, cyc);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; in_num_lights = 4'(nl); in_num_buttons = 4'(nb); in_buttons = b; in_target = t;
    @(negedge clk);
    in_valid = 0;
    in_buttons = {$urandom, $urandom, $urandom, $urandom, $urandom};
    in_target = NL'($urandom);
    n = 0;
    while (!out_valid && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("search_cycles", n, cyc);
    if (!out_valid) return;
    check("feasible", out_feasible, f);
    check("min_presses", out_min_presses, mn);
    check("buttons_to_press", out_buttons_to_press, set);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_set", out_buttons_to_press, set);
      check("stall_total", total_presses, tot);
    end
    out_ready = 1; clear_total = clr;
    @(negedge clk);
    out_ready = 0; clear_total = 0;
    if (clr) begin
      tot = 0; tot4 = 0; done = 0;
    end else begin
      done = (done + 1) % 65536;
      if (f) begin
        tot = tot + mn > 65535 ? 65535 : tot + mn;
        tot4 = tot4 + mn > 15 ? 15 : tot4 + mn;
      end
    end
    check("total", total_presses, tot);
    check("total_sat4", s_total, tot4);
    check("machines_done", machines_done, done);
    check("valid_dropped", out_valid, 0);
  endtask
  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_feasible", out_feasible, 0);
    check("rst_min", out_min_presses, 15);
    check("rst_set", out_buttons_to_press, 0);
    check("rst_total", total_presses, 0);
    check("rst_done", machines_done, 0);
  endtask
  initial begin
    logic [NB*NL-1:0] b;
    logic [NL-1:0] t;
    repeat (2) @(negedge clk);
    rst = 0;
    check_reset_values();
    b = '0;
    for (int k = 0; k < 5; k++) b[k*NL +: NL] = NL'(1 << k);
    for (int m = 0; m < 4; m++) begin
      run_machine(5, 5, b, 10'h1f, 0, 0);
      check("sat_seq", s_total, m == 3 ? 15 : 5 * (m + 1));
    end
    run_machine(5, 5, b, 10'h1f, 0, 1);
    check("clear_total", s_total, 0);
    check("clear_done", s_machines_done, 0);
    b = '0;
    b[0*NL +: NL] = 10'b1000; b[1*NL +: NL] = 10'b1010; b[2*NL +: NL] = 10'b0100;
    b[3*NL +: NL] = 10'b1100; b[4*NL +: NL] = 10'b0101; b[5*NL +: NL] = 10'b0011;
    run_machine(4, 6, b, 10'b0110, 0, 0);
    check("ex1_min", out_min_presses, 2);
    check("ex1_set", out_buttons_to_press, 13'b001010);
    check("ex1_total", total_presses, 2);
    b = '0; b[0 +: NL] = 10'b01;
    run_machine(2, 1, b, 10'b10, 0, 0);
    check("infeas_flag", out_feasible, 0);
    check("infeas_total", total_presses, 2);
    for (int k = 0; k < NB; k++) b[k*NL +: NL] = NL'($urandom);
    run_machine(10, 13, b, 10'h0, 0, 0);
    check("zero_target_min", out_min_presses, 0);
    run_machine(3, 0, b, 10'h3f8, 0, 0);
    run_machine(15, 15, b, NL'($urandom), 1, 0);
    run_machine(4, 6, b, 10'b0110, 5, 0);
    for (int m = 0; m < 30; m++) begin
      int nb = $urandom_range(0, 9);
      for (int k = 0; k < NB; k++) b[k*NL +: NL] = NL'($urandom);
      t = NL'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        t = '0;
        for (int k = 0; k < nb; k++) if ($urandom_range(0, 1) == 1) t = t ^ b[k*NL +: NL];
      end
      run_machine($urandom_range(0, 12), nb, b, t, $urandom_range(0, 2), 0);
    end
    for (int k = 0; k < NB; k++) b[k*NL +: NL] = NL'($urandom);
    in_valid = 1; in_num_lights = 10; in_num_buttons = 10; in_buttons = b; in_target = 10'h155;
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    check("mid_search_busy", in_ready, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    tot = 0; tot4 = 0; done = 0;
    check_reset_values();
    run_machine(4, 6, b, 10'b1001, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
